// File: rtl/scale_arb_pkg.sv
// Shared parameters and types for the two-requester scaler arbiter.
package scale_arb_pkg;

  localparam int W_DEF   = 8;
  localparam int LAT_DEF = 1;

  // Bit positions inside rsp_shift_o = {shift_r, shift_l, no_shift}
  localparam int SHIFT_NO_BIT = 0;
  localparam int SHIFT_L_BIT  = 1;
  localparam int SHIFT_R_BIT  = 2;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  function automatic logic [2:0] pack_shift(input logic r, input logic l, input logic n);
    logic [2:0] s;
    s = '0;
    s[SHIFT_R_BIT]  = r;
    s[SHIFT_L_BIT]  = l;
    s[SHIFT_NO_BIT] = n;
    return s;
  endfunction

endpackage

// File: rtl/scale_arb_if.sv
// Request, scaler and response signals of scale_arb; slave = arbiter side.
interface scale_arb_if #(parameter int W = scale_arb_pkg::W_DEF);

  logic [1:0]          req_valid_i;
  logic signed [W-1:0] req_x0_i;
  logic signed [W-1:0] req_x1_i;
  logic [1:0]          req_ready_o;
  logic signed [W-1:0] sc_x_o;
  logic signed [W-1:0] sc_x_scaled_i;
  logic                sc_shift_l_i;
  logic                sc_shift_r_i;
  logic                sc_no_shift_i;
  logic [1:0]          rsp_valid_o;
  logic signed [W-1:0] rsp_x_o;
  logic [2:0]          rsp_shift_o;
  logic                idle_o;

  modport slave (
    input  req_valid_i, req_x0_i, req_x1_i,
    input  sc_x_scaled_i, sc_shift_l_i, sc_shift_r_i, sc_no_shift_i,
    output req_ready_o, sc_x_o, rsp_valid_o, rsp_x_o, rsp_shift_o, idle_o
  );

  modport master (
    output req_valid_i, req_x0_i, req_x1_i,
    output sc_x_scaled_i, sc_shift_l_i, sc_shift_r_i, sc_no_shift_i,
    input  req_ready_o, sc_x_o, rsp_valid_o, rsp_x_o, rsp_shift_o, idle_o
  );

endinterface

// File: rtl/scale_arb_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last accepted requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // A grant is only ever given to a valid request, so any grant is an accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (|gnt)
      last <= gnt[1];
  end

endmodule

// File: rtl/scale_arb.sv
// Shares one fixed-latency scaler between two requesters and routes results back by tag.
module scale_arb
  import scale_arb_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  scale_arb_if.slave  bus
);

  localparam int CW = $clog2(LAT + 1);

  logic [1:0]          gnt;
  logic                accept;
  logic                retire;
  tag_t                tags [LAT];
  tag_t                tail;
  logic [CW-1:0]       cnt;
  logic [1:0]          rsp_valid;
  logic signed [W-1:0] rsp_x;
  logic [2:0]          rsp_shift;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.req_valid_i),
    .gnt (gnt)
  );

  assign accept = |gnt;
  assign tail   = tags[LAT-1];
  assign retire = tail.valid;

  assign bus.req_ready_o = gnt;
  assign bus.sc_x_o      = gnt[0] ? bus.req_x0_i :
                           gnt[1] ? bus.req_x1_i : '0;
  assign bus.idle_o      = (cnt == '0) && (bus.req_valid_i == 2'b00);
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_x_o     = rsp_x;
  assign bus.rsp_shift_o = rsp_shift;

  // Tags advance every edge in lockstep with the scaler's internal pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) tags[k] <= '0;
    end else begin
      tags[0] <= '{valid: accept, id: gnt[1]};
      for (int k = 1; k < LAT; k++) tags[k] <= tags[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (accept && !retire)
      cnt <= cnt + CW'(1);
    else if (!accept && retire)
      cnt <= cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 2'b00;
      rsp_x     <= '0;
      rsp_shift <= 3'b000;
    end else begin
      rsp_valid <= 2'b00;
      if (retire) begin
        rsp_valid[tail.id] <= 1'b1;
        rsp_x              <= bus.sc_x_scaled_i;
        rsp_shift          <= pack_shift(bus.sc_shift_r_i, bus.sc_shift_l_i, bus.sc_no_shift_i);
      end
    end
  end

endmodule

// File: tb/tb_scale_arb.sv
// Directed bench for scale_arb with a +1 scaler stub at LAT=1 (dut_a) and LAT=3 (dut_b).
module tb_scale_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scale_arb_if #(.W(8)) bus_a ();
  scale_arb_if #(.W(8)) bus_b ();

  scale_arb #(.W(8), .LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  scale_arb #(.W(8), .LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Scaler stubs: result = x + 1 after LAT edges, flags always no_shift
  logic signed [7:0] stg_a;
  logic signed [7:0] stg_b [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_a <= '0;
      for (int k = 0; k < 3; k++) stg_b[k] <= '0;
    end else begin
      stg_a    <= bus_a.sc_x_o;
      stg_b[0] <= bus_b.sc_x_o;
      stg_b[1] <= stg_b[0];
      stg_b[2] <= stg_b[1];
    end
  end

  assign bus_a.sc_x_scaled_i = stg_a + 8'sd1;
  assign bus_b.sc_x_scaled_i = stg_b[2] + 8'sd1;
  assign bus_a.sc_no_shift_i = 1'b1;
  assign bus_a.sc_shift_l_i  = 1'b0;
  assign bus_a.sc_shift_r_i  = 1'b0;
  assign bus_b.sc_no_shift_i = 1'b1;
  assign bus_b.sc_shift_l_i  = 1'b0;
  assign bus_b.sc_shift_r_i  = 1'b0;

  typedef struct {
    logic [1:0]        v;
    logic signed [7:0] x0;
    logic signed [7:0] x1;
    logic [1:0]        rdy;
    logic signed [7:0] scx;
    logic              idle;
    logic [1:0]        rv;
    logic signed [7:0] rx;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(input logic [1:0] v, input int x0, input int x1,
                              input logic [1:0] rdy, input int scx, input logic idle,
                              input logic [1:0] rv, input int rx);
    vec_t r;
    r.v = v; r.x0 = 8'(x0); r.x1 = 8'(x1); r.rdy = rdy; r.scx = 8'(scx);
    r.idle = idle; r.rv = rv; r.rx = 8'(rx);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic signed [7:0] x0, input logic signed [7:0] x1);
    bus_a.req_valid_i = v; bus_a.req_x0_i = x0; bus_a.req_x1_i = x1;
    bus_b.req_valid_i = v; bus_b.req_x0_i = x0; bus_b.req_x1_i = x1;
  endtask

  task automatic do_reset();
    drive(2'b00, 8'sd0, 8'sd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  exp_rv [8];
    logic [31:0] exp_cnt [8];
    int          pulses;

    // Latency/ordering table for the LAT=1 instance
    vt[0]  = mk(2'b01,  5,  0, 2'b01,  5, 1'b0, 2'b00,  0);
    vt[1]  = mk(2'b00,  0,  0, 2'b00,  0, 1'b0, 2'b01,  6);
    vt[2]  = mk(2'b00,  0,  0, 2'b00,  0, 1'b1, 2'b00,  6);
    vt[3]  = mk(2'b10,  0, -3, 2'b10, -3, 1'b0, 2'b00,  6);
    vt[4]  = mk(2'b10,  0, -2, 2'b10, -2, 1'b0, 2'b10, -2);
    vt[5]  = mk(2'b10,  0, -1, 2'b10, -1, 1'b0, 2'b10, -1);
    vt[6]  = mk(2'b10,  0,  0, 2'b10,  0, 1'b0, 2'b10,  0);
    vt[7]  = mk(2'b00,  0,  0, 2'b00,  0, 1'b0, 2'b10,  1);
    vt[8]  = mk(2'b11, 10, 20, 2'b01, 10, 1'b0, 2'b00,  1);
    vt[9]  = mk(2'b11, 10, 20, 2'b10, 20, 1'b0, 2'b01, 11);
    vt[10] = mk(2'b11, 10, 20, 2'b01, 10, 1'b0, 2'b10, 21);
    vt[11] = mk(2'b11, 10, 20, 2'b10, 20, 1'b0, 2'b01, 11);
    vt[12] = mk(2'b00,  0,  0, 2'b00,  0, 1'b0, 2'b10, 21);
    vt[13] = mk(2'b00,  0,  0, 2'b00,  0, 1'b1, 2'b00, 21);
    vt[14] = mk(2'b01,  7,  0, 2'b01,  7, 1'b0, 2'b00, 21);
    vt[15] = mk(2'b11,  7, 40, 2'b10, 40, 1'b0, 2'b01,  8);
    vt[16] = mk(2'b00,  0,  0, 2'b00,  0, 1'b0, 2'b10, 41);
    vt[17] = mk(2'b00,  0,  0, 2'b00,  0, 1'b1, 2'b00, 41);
    vt[18] = mk(2'b11,  3,  4, 2'b01,  3, 1'b0, 2'b00, 41);
    vt[19] = mk(2'b00,  0,  0, 2'b00,  0, 1'b0, 2'b01,  4);
    vt[20] = mk(2'b00,  0,  0, 2'b00,  0, 1'b1, 2'b00,  4);

    // Reset values, and no ready while reset is held
    drive(2'b11, 8'sd1, 8'sd2);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready_a", 32'(bus_a.req_ready_o), 32'd0);
    chk("reset ready_b", 32'(bus_b.req_ready_o), 32'd0);
    chk("reset rsp_valid", 32'(bus_a.rsp_valid_o), 32'd0);
    chk("reset rsp_x", 32'(bus_a.rsp_x_o), 32'd0);
    chk("reset rsp_shift", 32'(bus_a.rsp_shift_o), 32'd0);
    drive(2'b00, 8'sd0, 8'sd0);
    #1;
    chk("reset idle", 32'(bus_a.idle_o), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vt[i].v, vt[i].x0, vt[i].x1);
      @(negedge clk);
      chk($sformatf("vec%0d ready", i), 32'(bus_a.req_ready_o), 32'(vt[i].rdy));
      chk($sformatf("vec%0d sc_x", i), 32'(bus_a.sc_x_o), 32'(vt[i].scx));
      chk($sformatf("vec%0d idle", i), 32'(bus_a.idle_o), 32'(vt[i].idle));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d rsp_valid", i), 32'(bus_a.rsp_valid_o), 32'(vt[i].rv));
      chk($sformatf("vec%0d rsp_x", i), 32'(bus_a.rsp_x_o), 32'(vt[i].rx));
      if (vt[i].rv != 2'b00)
        chk($sformatf("vec%0d rsp_shift", i), 32'(bus_a.rsp_shift_o), 32'd1);
    end

    // LAT=3: single request, strobe exactly three edges after accept
    do_reset();
    drive(2'b01, 8'sd5, 8'sd0);
    @(posedge clk);
    #1 drive(2'b00, 8'sd0, 8'sd0);
    chk("lat3 edge0 rsp_valid", 32'(bus_b.rsp_valid_o), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat3 edge%0d rsp_valid", k), 32'(bus_b.rsp_valid_o), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) begin
        chk("lat3 rsp_x", 32'(bus_b.rsp_x_o), 32'(8'sd6));
        chk("lat3 rsp_shift", 32'(bus_b.rsp_shift_o), 32'd1);
      end
    end
    chk("lat3 idle after", 32'(bus_b.idle_o), 32'd1);

    // LAT=3: requester 1 stream, counter peaks at 3
    exp_cnt = '{1, 2, 3, 3, 2, 1, 0, 0};
    exp_rv  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    for (int j = 0; j < 8; j++) begin
      drive((j < 4) ? 2'b10 : 2'b00, 8'sd0, 8'(j - 3));
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d cnt", j), 32'(dut_b.cnt), exp_cnt[j]);
      chk($sformatf("stream%0d rsp_valid", j), 32'(bus_b.rsp_valid_o), 32'(exp_rv[j]));
      if (exp_rv[j] != 2'b00)
        chk($sformatf("stream%0d rsp_x", j), 32'(bus_b.rsp_x_o), 32'(8'(j - 5)));
    end

    // LAT=3: reset one edge after accept discards the in-flight tag
    drive(2'b01, 8'sd9, 8'sd0);
    @(posedge clk);
    #1 drive(2'b00, 8'sd0, 8'sd0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(2'b11, 8'sd1, 8'sd2);
    #2;
    chk("midrst ready_b", 32'(bus_b.req_ready_o), 32'd0);
    chk("midrst cnt", 32'(dut_b.cnt), 32'd0);
    drive(2'b00, 8'sd0, 8'sd0);
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (bus_b.rsp_valid_o != 2'b00) pulses++;
    end
    chk("midrst pulses", 32'(pulses), 32'd0);
    chk("midrst idle", 32'(bus_b.idle_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
